// File: rtl/fns_codec_5_2_if.sv
// Bus bundle for the fault-tolerant 7-TSV crosstalk-avoidance codec.
// The ftf_err signal exists only when FNS_CODEC_FTF_CHECK_EN is defined.
interface fns_codec_5_2_if #(
  parameter int DATA_W = 3,
  parameter int N_TSV  = 7
);
  logic [DATA_W-1:0] data_in;
  logic [N_TSV-1:0]  f_flag;
  logic [N_TSV-1:0]  en_flag;
  logic [N_TSV-1:0]  tsv;
  logic              code_ovf;
  logic [N_TSV-1:0]  tsv_in;
  logic [DATA_W-1:0] data_out;
`ifdef FNS_CODEC_FTF_CHECK_EN
  logic              ftf_err;
`endif

  modport master (
    output data_in, f_flag, tsv_in,
    input  en_flag, tsv, code_ovf, data_out
`ifdef FNS_CODEC_FTF_CHECK_EN
    , input ftf_err
`endif
  );

  modport slave (
    input  data_in, f_flag, tsv_in,
    output en_flag, tsv, code_ovf, data_out
`ifdef FNS_CODEC_FTF_CHECK_EN
    , output ftf_err
`endif
  );
endinterface

// File: rtl/fns_codec_5_2.sv
// Fault-tolerant FNS crosstalk-avoidance codec: registered encoder plus combinational decoder.
// Define FNS_CODEC_FTF_CHECK_EN to add the ftf_err output for raw forbidden-transition checking.
module fns_codec_5_2 #(
  parameter int DATA_W = 3,
  parameter int N_TSV  = 7
) (
  input  logic            clock,
  input  logic            rst_n,
  fns_codec_5_2_if.slave  bus
);

  localparam int NPAT = 1 << N_TSV;
  localparam int CW   = N_TSV + DATA_W + 1;

  // A pattern is legal when it avoids faulty lines and every odd line that is
  // high is flanked by high enabled even neighbours.
  function automatic logic isValid(input logic [N_TSV-1:0] p, input logic [N_TSV-1:0] en);
    logic ok;
    ok = ((p & ~en) == '0);
    for (int i = 1; i < N_TSV - 1; i += 2) begin
      if (p[i] && ((en[i-1] && !p[i-1]) || (en[i+1] && !p[i+1])))
        ok = 1'b0;
    end
    return ok;
  endfunction

  logic [N_TSV-1:0]  w_enFlag;
  logic [N_TSV-1:0]  w_encWord;
  logic [N_TSV-1:0]  w_masked;
  logic [CW-1:0]     w_capacity;
  logic [CW-1:0]     w_dataExt;
  logic [DATA_W-1:0] w_rank;
  logic              w_overflow;
  logic              w_maskedValid;
  logic [N_TSV-1:0]  r_tsv;
  logic              r_codeOvf;

  assign w_enFlag  = ~bus.f_flag;
  assign w_dataExt = CW'(bus.data_in);

  // Walk patterns in ascending order; the one reached when the running count equals data_in is its codeword.
  always_comb begin
    w_encWord  = '0;
    w_capacity = '0;
    for (int p = 0; p < NPAT; p++) begin
      if (isValid(N_TSV'(p), w_enFlag)) begin
        if (w_capacity == w_dataExt)
          w_encWord = N_TSV'(p);
        w_capacity = w_capacity + CW'(1);
      end
    end
  end

  assign w_overflow = (w_dataExt >= w_capacity);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_tsv     <= '0;
      r_codeOvf <= 1'b0;
    end else begin
      r_tsv     <= w_overflow ? '0 : w_encWord;
      r_codeOvf <= w_overflow;
    end
  end

  assign w_masked      = bus.tsv_in & w_enFlag;
  assign w_maskedValid = isValid(w_masked, w_enFlag);

  // Rank is the count of legal patterns below the received one; wrapping the counter truncates it.
  always_comb begin
    w_rank = '0;
    for (int p = 0; p < NPAT; p++) begin
      if ((N_TSV'(p) < w_masked) && isValid(N_TSV'(p), w_enFlag))
        w_rank = w_rank + DATA_W'(1);
    end
  end

  assign bus.en_flag  = w_enFlag;
  assign bus.tsv      = r_tsv;
  assign bus.code_ovf = r_codeOvf;

`ifdef FNS_CODEC_FTF_CHECK_EN
  logic w_ftfErr;
  assign w_ftfErr     = !isValid(bus.tsv_in, w_enFlag);
  assign bus.ftf_err  = w_ftfErr;
  assign bus.data_out = (w_maskedValid && !w_ftfErr) ? w_rank : '0;
`else
  assign bus.data_out = w_maskedValid ? w_rank : '0;
`endif

endmodule

// File: tb/tb_fns_codec_5_2.sv
// Scoreboard bench for fns_codec_5_2: stimulus pushes expectations, a monitor pops and compares.
// Expectations for ftf_err and forced-zero decode apply when FNS_CODEC_FTF_CHECK_EN is defined.
module tb_fns_codec_5_2;

  localparam int DATA_W = 3;

  typedef struct {
    int         id;
    logic       chkTsv;
    logic [6:0] expTsv;
    logic       chkOvf;
    logic       expOvf;
    logic       chkData;
    logic [2:0] expData;
    logic       chkEn;
    logic [6:0] expEn;
    logic       chkFtf;
    logic       expFtf;
    logic       chkProp;
    logic [6:0] fFlag;
    logic [2:0] dataIn;
  } expT;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       loopMode;
  logic [6:0] tsvInDrv;
  expT        sbQ[$];
  int         checks = 0;
  int         errors = 0;
  logic [6:0] prevTsv = '0;
  event       asyncSample;

  fns_codec_5_2_if #(.DATA_W(DATA_W)) bus ();

  assign bus.tsv_in = loopMode ? bus.tsv : tsvInDrv;

  fns_codec_5_2 #(.DATA_W(DATA_W)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic expT blankExp(input int id);
    expT e;
    e = '{default: '0};
    e.id = id;
    return e;
  endfunction

  function automatic expT mkEnc(input int id, input logic [2:0] d, input logic [6:0] f,
                                input logic [6:0] expTsv, input logic expOvf);
    expT e;
    e = blankExp(id);
    e.chkTsv  = 1'b1;  e.expTsv  = expTsv;
    e.chkOvf  = 1'b1;  e.expOvf  = expOvf;
    e.chkData = 1'b1;  e.expData = expOvf ? 3'd0 : d;
    e.chkEn   = 1'b1;  e.expEn   = ~f;
    e.chkFtf  = 1'b1;  e.expFtf  = 1'b0;
    return e;
  endfunction

  task automatic cmp(input string what, input int id, input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s vec %0d got %b want %b", what, id, got, want);
    end
  endtask

  task automatic checkOutput(input expT e);
    logic [6:0] viol;
    if (e.chkTsv)  cmp("tsv", e.id, bus.tsv, e.expTsv);
    if (e.chkOvf)  cmp("code_ovf", e.id, 7'(bus.code_ovf), 7'(e.expOvf));
    if (e.chkData) cmp("data_out", e.id, 7'(bus.data_out), 7'(e.expData));
    if (e.chkEn)   cmp("en_flag", e.id, bus.en_flag, e.expEn);
`ifdef FNS_CODEC_FTF_CHECK_EN
    if (e.chkFtf)  cmp("ftf_err", e.id, 7'(bus.ftf_err), 7'(e.expFtf));
`endif
    if (e.chkProp) begin
      viol = '0;
      for (int i = 1; i < 6; i += 2) begin
        if (bus.tsv[i] && ((!e.fFlag[i-1] && !bus.tsv[i-1]) || (!e.fFlag[i+1] && !bus.tsv[i+1])))
          viol[i] = 1'b1;
      end
      cmp("fault_line", e.id, bus.tsv & e.fFlag, 7'd0);
      cmp("odd_rule", e.id, viol, 7'd0);
      cmp("sweep_ovf", e.id, 7'(bus.code_ovf), 7'd0);
      cmp("roundtrip", e.id, 7'(bus.data_out), 7'(e.dataIn));
      if (e.dataIn == 3'd0)
        cmp("rank0", e.id, bus.tsv, 7'd0);
      else
        cmp("ascending", e.id, 7'(bus.tsv > prevTsv), 7'd1);
      prevTsv = bus.tsv;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] d, input logic [6:0] f, input logic lb,
                               input logic [6:0] tin, input expT e);
    @(negedge clock);
    bus.data_in = d;
    bus.f_flag  = f;
    loopMode    = lb;
    tsvInDrv    = tin;
    sbQ.push_back(e);
  endtask

  task automatic encVec(input int id, input logic [2:0] d, input logic [6:0] f,
                        input logic [6:0] expTsv, input logic expOvf);
    applyStimulus(d, f, 1'b1, 7'd0, mkEnc(id, d, f, expTsv, expOvf));
  endtask

  task automatic decVec(input int id, input logic [6:0] f, input logic [6:0] tin,
                        input logic [2:0] expData, input logic expFtf);
    expT e;
    e = blankExp(id);
    e.chkData = 1'b1;  e.expData = expData;
    e.chkEn   = 1'b1;  e.expEn   = ~f;
    e.chkFtf  = 1'b1;  e.expFtf  = expFtf;
    applyStimulus(3'd0, f, 1'b0, tin, e);
  endtask

  task automatic sweepVec(input int id, input logic [2:0] d, input logic [6:0] f);
    expT e;
    e = blankExp(id);
    e.chkProp = 1'b1;  e.fFlag = f;  e.dataIn = d;
    e.chkEn   = 1'b1;  e.expEn = ~f;
    applyStimulus(d, f, 1'b1, 7'd0, e);
  endtask

  // Monitor: the DUT presents a result after every rising edge, or on demand for async reset.
  initial begin
    forever begin
      @(posedge clock or asyncSample);
      #1;
      if (sbQ.size() > 0)
        checkOutput(sbQ.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    expT e;
    int  id;
    rst_n       = 1'b0;
    bus.data_in = '0;
    bus.f_flag  = '0;
    loopMode    = 1'b1;
    tsvInDrv    = '0;

    e = blankExp(1);
    e.chkTsv = 1'b1;  e.chkOvf = 1'b1;
    applyStimulus(3'd5, 7'd0, 1'b1, 7'd0, e);
    e.id = 2;
    applyStimulus(3'd7, 7'd0, 1'b1, 7'd0, e);

    @(negedge clock);
    bus.data_in = 3'd4;
    #1 rst_n = 1'b1;
    sbQ.push_back(mkEnc(3, 3'd4, 7'd0, 7'b0000111, 1'b0));

    encVec(4,  3'd0, 7'b0000000, 7'b0000000, 1'b0);
    encVec(5,  3'd1, 7'b0000000, 7'b0000001, 1'b0);
    encVec(6,  3'd2, 7'b0000000, 7'b0000100, 1'b0);
    encVec(7,  3'd3, 7'b0000000, 7'b0000101, 1'b0);
    encVec(8,  3'd4, 7'b0000000, 7'b0000111, 1'b0);
    encVec(9,  3'd5, 7'b0000000, 7'b0010000, 1'b0);
    encVec(10, 3'd6, 7'b0000000, 7'b0010001, 1'b0);
    encVec(11, 3'd7, 7'b0000000, 7'b0010100, 1'b0);
    encVec(12, 3'd7, 7'b0000001, 7'b0011110, 1'b0);
    encVec(13, 3'd5, 7'b0010100, 7'b0001011, 1'b0);
    encVec(14, 3'd1, 7'b1111110, 7'b0000001, 1'b0);
    encVec(15, 3'd2, 7'b1111110, 7'b0000000, 1'b1);
    encVec(16, 3'd0, 7'b1111111, 7'b0000000, 1'b0);
    encVec(17, 3'd3, 7'b1111111, 7'b0000000, 1'b1);
    encVec(18, 3'd7, 7'b0000000, 7'b0010100, 1'b0);

    @(negedge clock);
    #2 rst_n = 1'b0;
    e = blankExp(19);
    e.chkTsv = 1'b1;  e.chkOvf = 1'b1;
    sbQ.push_back(e);
    ->asyncSample;
    @(negedge clock);
    rst_n = 1'b1;

    decVec(20, 7'b0000000, 7'b0000010, 3'd0, 1'b1);
    decVec(21, 7'b0000000, 7'b1111111, 3'd1, 1'b0);
    decVec(22, 7'b0010100, 7'b0001011, 3'd5, 1'b0);
    decVec(23, 7'b0000000, 7'b0001000, 3'd0, 1'b1);
    decVec(24, 7'b0000000, 7'b0010100, 3'd7, 1'b0);
`ifdef FNS_CODEC_FTF_CHECK_EN
    decVec(25, 7'b0000001, 7'b0011111, 3'd0, 1'b1);
`else
    decVec(25, 7'b0000001, 7'b0011111, 3'd7, 1'b0);
`endif

    id = 100;
    for (int a = 0; a < 7; a++) begin
      for (int b = a; b < 7; b++) begin
        for (int d = 0; d < 8; d++) begin
          sweepVec(id, 3'(d), 7'(1 << a) | 7'(1 << b));
          id++;
        end
      end
    end

    repeat (3) @(negedge clock);
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d want 0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fns_codec_5_2.md
Name: fns_codec_5_2

Overview:
- Fault-tolerant crosstalk-avoidance codec for a 7-TSV link (5 data lines plus 2 spares).
- Encodes a DATA_W-bit word into a 7-bit TSV pattern that satisfies the forbidden-transition rule among enabled lines. Faulty lines are skipped.
- A combinational decoder recovers the word from the received pattern.
- Encoder and decoder each derive the enable mask and per-position codeword counts from the same fault flags; these are the FNS adders, internal to the block.

Parameters:
- DATA_W, 3, payload width. The 3-bit capacity is guaranteed for up to 2 faulty lines.
- N_TSV, 7, number of TSV lines. Fixed; other values are not supported.

Ports:
- clock  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- data_in  in  DATA_W  word to encode
- f_flag  in  7  fault flags; bit i=1 means TSV i is faulty. Static during operation.
- en_flag  out  7  enable mask, ~f_flag (combinational)
- tsv  out  7  registered encoded TSV pattern
- code_ovf  out  1  registered; data_in was at or above the current code capacity
- tsv_in  in  7  received TSV pattern, decoder side
- data_out  out  DATA_W  decoded word (combinational)

Behaviour:
- Valid codeword under en (pattern p, bits 0..6):
  - p[i]=0 for every disabled i.
  - For odd i in {1,3,5}, if p[i]=1, then every enabled even neighbour (i-1, i+1) must be 1.
  - Disabled neighbours impose no constraint.
- Code order: valid codewords are ranked in ascending unsigned 7-bit value. Rank 0 is always 0000000.
- Capacity C(en): the number of valid codewords. C is at least 13 for 2 or fewer faults, so every DATA_W=3 value is encodable.
- Encoder, on each rising clock edge:
  - tsv <= codeword of rank data_in under the current en_flag; code_ovf <= 0.
  - If data_in >= C: tsv <= 0 and code_ovf <= 1.
  - Latency is 1 cycle.
- Reset (rst_n low, asynchronous): tsv=0, code_ovf=0.
  - Reset mid-operation clears the outputs immediately.
  - The first edge after release encodes the data_in present at that edge.
- Decoder (combinational):
  - Mask tsv_in with en_flag.
  - If the masked pattern is valid, data_out = its rank, truncated to DATA_W.
  - If the masked pattern is invalid, data_out = 0.
- Round trip: data_out equals the registered data_in whenever code_ovf=0, the same f_flag drives both sides, and tsv_in=tsv.
- Implementation: enumerative weights (per-position count of valid completions, the FNS adders) plus greedy MSB-first selection; a fully combinational ranking is equally acceptable. Ranks must match the order defined above exactly.
- f_flag change: takes effect for the encoder at the next clock edge and for the decoder immediately.

Optional Feature:
- Macro: FNS_CODEC_FTF_CHECK_EN.
- Defined: adds output ftf_err (1 bit, combinational). ftf_err=1 when tsv_in has a 1 on a disabled line or violates the odd-line rule; data_out is then forced to 0.
- Undefined: the port is absent, and invalid patterns decode to 0 silently.

Test Plan:
- rst_n=0 with clock toggling -> tsv=0000000, code_ovf=0. Release, data_in=0 -> tsv=0000000, data_out=0.
- f_flag=0: data_in 1, 2, 3, 4, 7 -> tsv 0000001, 0000100, 0000101, 0000111, 0010100 respectively. Round trip data_out=data_in.
- f_flag=0000001: data_in=7 -> tsv=0011110, en_flag=1111110, data_out=7.
- f_flag=0010100: data_in=5 -> tsv=0001011, data_out=5. Also sweep every single fault and fault pair with all 8 values -> no odd-line violation on enabled neighbours, and round trip exact.
- Decoder stimulus tsv_in=0000010, f_flag=0 -> data_out=0. With FNS_CODEC_FTF_CHECK_EN defined -> ftf_err=1.
- Assert rst_n low mid-stream with tsv=0010100 -> tsv drops to 0 asynchronously, before the next edge.
